// File: rtl/txn_pkg.sv
// txn_pkg: state encoding, error codes and a width helper shared by the
// transaction sequencer and its testbench.
package txn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READY = 3'd3,
        ST_TXN   = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FAIL    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // A field index needs at least one bit even when only one field exists.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/txn_sequencer_if.sv
// txn_sequencer_if: board-side controls and datapath/animation handshakes of
// the transaction sequencer; the sequencer connects through the slave modport.
interface txn_sequencer_if #(
    parameter int FIELD_W = 1,
    parameter int CNT_W   = 8
) ();

    logic               load_signal;
    logic               start_signal;
    logic               cancel_signal;
    logic               finished_transaction;
    logic               txn_fail;

    logic               load_screen;
    logic               reset_data;
    logic               load_en;
    logic [FIELD_W-1:0] field_sel;
    logic               start_transaction;
    logic               busy;
    logic [1:0]         error_code;
    logic [CNT_W-1:0]   txn_count;

    modport master (
        output load_signal, start_signal, cancel_signal, finished_transaction, txn_fail,
        input  load_screen, reset_data, load_en, field_sel, start_transaction, busy,
               error_code, txn_count
    );

    modport slave (
        input  load_signal, start_signal, cancel_signal, finished_transaction, txn_fail,
        output load_screen, reset_data, load_en, field_sel, start_transaction, busy,
               error_code, txn_count
    );

endinterface

// File: rtl/txn_watchdog.sv
// txn_watchdog: counts enabled cycles since the last clear and flags expiry
// once TIMEOUT_CYCLES-1 has been reached.
module txn_watchdog #(
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/txn_sequencer.sv
// txn_sequencer: Moore FSM sequencing NUM_FIELDS field loads, a transaction
// run and error reporting. Define TXN_TIMEOUT_EN to add the TXN watchdog.
module txn_sequencer
    import txn_pkg::*;
#(
    parameter int NUM_FIELDS = 2,
    parameter int FIELD_W    = txn_pkg::sel_width(NUM_FIELDS),
    parameter int CNT_W      = 8
`ifdef TXN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
    input  logic           clock,
    input  logic           resetn,
    txn_sequencer_if.slave bus
);

    localparam logic [FIELD_W-1:0] K_LAST = FIELD_W'(NUM_FIELDS - 1);

    state_t             r_state, w_next_state;
    logic [FIELD_W-1:0] r_k, w_next_k;
    logic               r_first_load;
    logic [1:0]         r_error_code, w_next_error;
    logic [CNT_W-1:0]   r_txn_count;
    logic               w_count_inc;
    logic               w_expired;

`ifdef TXN_TIMEOUT_EN
    // Held clear outside TXN, so the count restarts from zero on every entry.
    txn_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk       (clock),
        .rst_n     (resetn),
        .i_clear   (r_state != ST_TXN),
        .i_enable  (r_state == ST_TXN),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_k     = r_k;
        w_next_error = r_error_code;
        w_count_inc  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.load_signal) begin
                    w_next_state = ST_LOAD;
                    w_next_k     = '0;
                end
            end
            ST_LOAD: begin
                if (bus.cancel_signal) begin
                    w_next_state = ST_IDLE;
                    w_next_k     = '0;
                end else if (!bus.load_signal) begin
                    if (r_k < K_LAST) begin
                        w_next_state = ST_WAIT;
                        w_next_k     = r_k + 1'b1;
                    end else begin
                        w_next_state = ST_READY;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.cancel_signal) begin
                    w_next_state = ST_IDLE;
                    w_next_k     = '0;
                end else if (bus.load_signal) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_READY: begin
                if (bus.cancel_signal) begin
                    w_next_state = ST_IDLE;
                    w_next_k     = '0;
                end else if (bus.start_signal) begin
                    w_next_state = ST_TXN;
                end
            end
            ST_TXN: begin
                // A completion in the expiry cycle still counts as a completion.
                if (bus.finished_transaction) begin
                    if (bus.txn_fail) begin
                        w_next_state = ST_ERROR;
                        w_next_error = ERR_FAIL;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_k     = '0;
                        w_count_inc  = 1'b1;
                    end
                end else if (w_expired) begin
                    w_next_state = ST_ERROR;
                    w_next_error = ERR_TIMEOUT;
                end
            end
            ST_ERROR: begin
                if (bus.start_signal) begin
                    w_next_state = ST_IDLE;
                    w_next_error = ERR_NONE;
                    w_next_k     = '0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_k     = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_k          <= '0;
            r_first_load <= 1'b0;
            r_error_code <= ERR_NONE;
            r_txn_count  <= '0;
        end else begin
            r_k          <= w_next_k;
            r_first_load <= (r_state == ST_IDLE) && (w_next_state == ST_LOAD);
            r_error_code <= w_next_error;
            if (w_count_inc && (r_txn_count != {CNT_W{1'b1}})) begin
                r_txn_count <= r_txn_count + 1'b1;
            end
        end
    end

    assign bus.load_screen       = (r_state == ST_IDLE) || (r_state == ST_ERROR);
    assign bus.reset_data        = (r_state == ST_LOAD) && r_first_load;
    assign bus.load_en           = (r_state == ST_LOAD);
    assign bus.field_sel         = ((r_state == ST_LOAD) || (r_state == ST_WAIT)) ? r_k : '0;
    assign bus.start_transaction = (r_state == ST_TXN);
    assign bus.busy              = (r_state != ST_IDLE);
    assign bus.error_code        = r_error_code;
    assign bus.txn_count         = r_txn_count;

endmodule

// File: tb/tb_txn_sequencer.sv
// tb_txn_sequencer: scoreboard bench for txn_sequencer with NUM_FIELDS=3 and
// CNT_W=2; the watchdog scenario follows TXN_TIMEOUT_EN.
module tb_txn_sequencer;

    localparam int NF = 3;
    localparam int FW = 2;
    localparam int CW = 2;
`ifdef TXN_TIMEOUT_EN
    localparam int TO = 10;
`endif

    typedef struct packed {
        logic       ls;
        logic       rd;
        logic       le;
        logic [1:0] fs;
        logic       st;
        logic       bz;
        logic [1:0] er;
        logic [1:0] cn;
    } outs_t;

    typedef struct packed {
        logic  ld;
        logic  sr;
        logic  cc;
        logic  fn;
        logic  fl;
        outs_t exp;
    } stim_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    total = 0;
    int    bad   = 0;
    int    exp_cnt = 0;
    stim_t plan[$];
    outs_t sb[$];

    always #5 clk = ~clk;

    txn_sequencer_if #(.FIELD_W(FW), .CNT_W(CW)) bus_if ();

    txn_sequencer #(
        .NUM_FIELDS(NF),
        .FIELD_W   (FW),
        .CNT_W     (CW)
`ifdef TXN_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clock (clk),
        .resetn(rst_n),
        .bus   (bus_if)
    );

    function automatic outs_t o(input logic ls, input logic rd, input logic le,
                                input logic [1:0] fs, input logic st, input logic bz,
                                input logic [1:0] er, input logic [1:0] cn);
        outs_t r;
        r.ls = ls; r.rd = rd; r.le = le; r.fs = fs;
        r.st = st; r.bz = bz; r.er = er; r.cn = cn;
        return r;
    endfunction

    function automatic outs_t sample();
        outs_t r;
        r.ls = bus_if.load_screen;
        r.rd = bus_if.reset_data;
        r.le = bus_if.load_en;
        r.fs = bus_if.field_sel;
        r.st = bus_if.start_transaction;
        r.bz = bus_if.busy;
        r.er = bus_if.error_code;
        r.cn = bus_if.txn_count;
        return r;
    endfunction

    task automatic add(input logic ld, input logic sr, input logic cc,
                       input logic fn, input logic fl, input outs_t e);
        stim_t s;
        s.ld = ld; s.sr = sr; s.cc = cc; s.fn = fn; s.fl = fl; s.exp = e;
        plan.push_back(s);
    endtask

    task automatic apply(input stim_t s);
        bus_if.load_signal          = s.ld;
        bus_if.start_signal         = s.sr;
        bus_if.cancel_signal        = s.cc;
        bus_if.finished_transaction = s.fn;
        bus_if.txn_fail             = s.fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three press/release pairs: LOAD(0) WAIT(1) LOAD(1) WAIT(2) LOAD(2) READY.
    task automatic plan_to_ready();
        logic [1:0] c;
        c = 2'(exp_cnt);
        add(1, 0, 0, 0, 0, o(0, 1, 1, 2'd0, 0, 1, 2'd0, c));
        add(0, 0, 0, 0, 0, o(0, 0, 0, 2'd1, 0, 1, 2'd0, c));
        add(1, 0, 0, 0, 0, o(0, 0, 1, 2'd1, 0, 1, 2'd0, c));
        add(0, 0, 0, 0, 0, o(0, 0, 0, 2'd2, 0, 1, 2'd0, c));
        add(1, 0, 0, 0, 0, o(0, 0, 1, 2'd2, 0, 1, 2'd0, c));
        add(0, 0, 0, 0, 0, o(0, 0, 0, 2'd0, 0, 1, 2'd0, c));
    endtask

    task automatic plan_txn(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, o(0, 0, 0, 2'd0, 1, 1, 2'd0, 2'(exp_cnt)));
    endtask

    task automatic plan_start();
        add(0, 1, 0, 0, 0, o(0, 0, 0, 2'd0, 1, 1, 2'd0, 2'(exp_cnt)));
    endtask

    task automatic plan_finish_ok();
        exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
        add(0, 0, 0, 1, 0, o(1, 0, 0, 2'd0, 0, 0, 2'd0, 2'(exp_cnt)));
    endtask

    task automatic test_reset();
        outs_t got, want;
        apply('0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got  = sample();
        want = o(1, 0, 0, 2'd0, 0, 0, 2'd0, 2'd0);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_state: got=%b want=%b", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        got = sample();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_release_idle: got=%b want=%b", got, want);
        end
    endtask

    task automatic test_three_fields();
        stim_t s;
        outs_t got, want;
        plan_to_ready();
        add(1, 0, 0, 0, 0, o(0, 0, 0, 2'd0, 0, 1, 2'd0, 2'(exp_cnt)));
        plan_start();
        plan_txn(3);
        plan_finish_ok();
        for (int step = 0; plan.size() != 0; step++) begin
            s = plan.pop_front();
            apply(s);
            sb.push_back(s.exp);
            tick();
            got  = sample();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL three_fields step %0d: got=%b want=%b", step, got, want);
            end
        end
    endtask

    task automatic test_hold_and_cancel();
        stim_t s;
        outs_t got, want;
        logic [1:0] c;
        c = 2'(exp_cnt);
        add(0, 0, 1, 0, 0, o(1, 0, 0, 2'd0, 0, 0, 2'd0, c));
        add(1, 0, 0, 0, 0, o(0, 1, 1, 2'd0, 0, 1, 2'd0, c));
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, o(0, 0, 1, 2'd0, 0, 1, 2'd0, c));
        add(0, 0, 0, 0, 0, o(0, 0, 0, 2'd1, 0, 1, 2'd0, c));
        add(1, 0, 1, 0, 0, o(1, 0, 0, 2'd0, 0, 0, 2'd0, c));
        add(1, 0, 0, 0, 0, o(0, 1, 1, 2'd0, 0, 1, 2'd0, c));
        add(1, 0, 1, 0, 0, o(1, 0, 0, 2'd0, 0, 0, 2'd0, c));
        plan_to_ready();
        add(0, 1, 1, 0, 0, o(1, 0, 0, 2'd0, 0, 0, 2'd0, c));
        for (int step = 0; plan.size() != 0; step++) begin
            s = plan.pop_front();
            apply(s);
            sb.push_back(s.exp);
            tick();
            got  = sample();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL hold_cancel step %0d: got=%b want=%b", step, got, want);
            end
        end
    endtask

    task automatic test_txn_fail();
        stim_t s;
        outs_t got, want;
        logic [1:0] c;
        c = 2'(exp_cnt);
        plan_to_ready();
        plan_start();
        add(0, 0, 1, 0, 0, o(0, 0, 0, 2'd0, 1, 1, 2'd0, c));
        add(1, 0, 0, 0, 0, o(0, 0, 0, 2'd0, 1, 1, 2'd0, c));
        add(0, 0, 0, 1, 1, o(1, 0, 0, 2'd0, 0, 1, 2'd1, c));
        add(1, 0, 1, 0, 0, o(1, 0, 0, 2'd0, 0, 1, 2'd1, c));
        add(0, 1, 0, 0, 0, o(1, 0, 0, 2'd0, 0, 0, 2'd0, c));
        for (int step = 0; plan.size() != 0; step++) begin
            s = plan.pop_front();
            apply(s);
            sb.push_back(s.exp);
            tick();
            got  = sample();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL txn_fail step %0d: got=%b want=%b", step, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        outs_t got, want;
        plan_to_ready();
        plan_start();
`ifdef TXN_TIMEOUT_EN
        plan_txn(TO - 1);
        add(0, 0, 0, 0, 0, o(1, 0, 0, 2'd0, 0, 1, 2'd2, 2'(exp_cnt)));
        add(0, 1, 0, 0, 0, o(1, 0, 0, 2'd0, 0, 0, 2'd0, 2'(exp_cnt)));
        plan_to_ready();
        plan_start();
        plan_txn(TO - 1);
        plan_finish_ok();
`else
        plan_txn(30);
        plan_finish_ok();
`endif
        for (int step = 0; plan.size() != 0; step++) begin
            s = plan.pop_front();
            apply(s);
            sb.push_back(s.exp);
            tick();
            got  = sample();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL timeout step %0d: got=%b want=%b", step, got, want);
            end
        end
    endtask

    task automatic test_saturate_and_reset();
        stim_t s;
        outs_t got, want;
        for (int t = 0; t < 5; t++) begin
            plan_to_ready();
            plan_start();
            plan_txn(1);
            plan_finish_ok();
        end
        plan_to_ready();
        plan_start();
        plan_txn(2);
        for (int step = 0; plan.size() != 0; step++) begin
            s = plan.pop_front();
            apply(s);
            sb.push_back(s.exp);
            tick();
            got  = sample();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL saturate step %0d: got=%b want=%b", step, got, want);
            end
        end
        // Asynchronous reset mid-cycle while TXN is running.
        #3;
        rst_n = 1'b0;
        #1;
        got  = sample();
        want = o(1, 0, 0, 2'd0, 0, 0, 2'd0, 2'd0);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL async_reset_mid_txn: got=%b want=%b", got, want);
        end
        apply('0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        plan_to_ready();
        plan_start();
        plan_finish_ok();
        for (int step = 0; plan.size() != 0; step++) begin
            s = plan.pop_front();
            apply(s);
            sb.push_back(s.exp);
            tick();
            got  = sample();
            want = sb.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL after_reset step %0d: got=%b want=%b", step, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_fields();
        test_hold_and_cancel();
        test_txn_fail();
        test_timeout();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
